dma_xfer_engine: RTL and testbench
==================================

# dma_xfer_engine

Transfer engine sitting directly downstream of the DMA register file. It consumes the register file's `start` pulse, source (tx) address, destination (rx) address and length. It then moves `data_len` words one at a time from source memory to destination memory over a simple request/handshake memory port, reporting `busy` and a one-cycle `done` back toward the status path.

## Interface
Parameters:
- `WIDTH`, 8, width of addresses, data words, length and count.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `arst_n`  in  1  asynchronous, active-high reset (asserted = 1, despite the name).
- `start`  in  1  one-cycle start pulse from the register file.
- `src_addr`  in  WIDTH  first source address; taken from the register file tx address.
- `dst_addr`  in  WIDTH  first destination address; taken from the register file rx address.
- `data_len`  in  WIDTH  number of words to move; 0 means none.
- `mem_rd_req`  out  1  read request.
- `mem_rd_addr`  out  WIDTH  read address.
- `mem_rd_valid`  in  1  read data valid; completes the read.
- `mem_rd_data`  in  WIDTH  read data.
- `mem_wr_req`  out  1  write request.
- `mem_wr_addr`  out  WIDTH  write address.
- `mem_wr_data`  out  WIDTH  write data.
- `mem_wr_ack`  in  1  write accepted; completes the write.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of transfer.
- `xfer_count`  out  WIDTH  words completed in current/last transfer.

## Operation
- The FSM has four states: IDLE, RD, WR, DONE.
- **IDLE:**
  - On `start`=1, capture `src_addr`, `dst_addr` and `data_len` into internal pointer and length registers, and clear `xfer_count` to 0.
  - If the captured length is nonzero, go to RD; if it is 0, go directly to DONE.
  - No memory request is issued in IDLE.
- **RD:**
  - `mem_rd_req`=1 and `mem_rd_addr`=src pointer, both held stable until `mem_rd_valid`=1.
  - On valid, latch `mem_rd_data` into the data buffer and go to WR.
  - Valid may arrive in the first RD cycle (zero-wait memory).
- **WR:**
  - `mem_wr_req`=1, `mem_wr_addr`=dst pointer and `mem_wr_data`=buffer, all held stable until `mem_wr_ack`=1.
  - On ack: src pointer +1, dst pointer +1, `xfer_count` +1.
  - Then, if the new count equals the captured length, go to DONE; otherwise go to RD.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE. `xfer_count` holds its final value until the next accepted start.
- `mem_rd_req`/`mem_wr_req` are decoded from state only. They are never both high, and they are never high outside RD/WR.
- Address arithmetic is modulo 2^WIDTH: pointer 0xFF + 1 = 0x00, with no error.
- `start` is ignored in RD, WR and DONE. Register file inputs changing mid-transfer have no effect, because they are captured at start.
- `mem_rd_valid` outside RD and `mem_wr_ack` outside WR are ignored.
- Reset (async, any state, including mid-handshake):
  - state=IDLE; all internal registers 0.
  - `busy`=0, `done`=0, `mem_rd_req`=0, `mem_wr_req`=0, `mem_rd_addr`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `xfer_count`=0.
  - The interrupted word is not retried after reset.

## Timing
- Start accepted at edge N: `busy`=1 and `mem_rd_req`=1 from cycle N+1.
- Zero-wait memory (valid/ack in the same cycle as the request) gives 2 cycles per word.
- Total with zero-wait memory: start edge to `done` pulse = 2·L+1 cycles, for length L ≥ 1.
- Each wait cycle on valid/ack adds exactly one cycle.
- Length 0: `done` is high in cycle N+1 and the state is back in IDLE at N+2. `busy` is high only in that DONE cycle.
- `start` arriving in the same cycle as `done` is ignored, because the FSM is not in IDLE. The earliest accepted restart is the cycle after DONE.
- `busy` falls in the same cycle that `done` falls (entry to IDLE).
- `xfer_count` updates on the edge that samples `mem_wr_ack`.

## Test plan
- **Reset mid-transfer:** assert `arst_n` while in WR with `mem_wr_req`=1 → all outputs 0 asynchronously. A new start after release restarts from freshly captured addresses.
- **Single zero-wait transfer:** src=0x10, dst=0x40, len=3, memory returns src+0x80 → writes at 0x40/0x41/0x42 with data 0x90/0x91/0x92; `done` at start+7; `xfer_count`=3.
- **Wait states:** len=2, valid delayed 3 cycles and ack delayed 2 cycles on each word → requests and addresses held stable throughout; `done` at start+15; no duplicate writes.
- **Wrap-around:** src=0xFE, dst=0xFF, len=3 → reads 0xFE, 0xFF, 0x00 and writes 0xFF, 0x00, 0x01.
- **Zero length:** len=0 with start → no memory request; `done`=1 and `busy`=1 in cycle N+1; `xfer_count`=0.
- **Start while busy:**
  - Stimulus: during a len=4 transfer, pulse start with different addresses and length, and change `data_len` mid-transfer.
  - Response: the original transfer completes unaltered (4 words at the original addresses); exactly one `done` pulse.

Source files
------------

// File: rtl/dma_xfer_engine.sv
// Single-channel DMA transfer engine: copies data_len words from src to dst, one read and one
// write at a time, over a request/handshake memory port.
module dma_xfer_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] data_len,
    output logic             mem_rd_req,
    output logic [WIDTH-1:0] mem_rd_addr,
    input  logic             mem_rd_valid,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_req,
    output logic [WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic             mem_wr_ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] xfer_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] count_inc;

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign count_inc = count_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        buf_d   = buf_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = data_len;
                    count_d = '0;
                    state_d = (data_len != '0) ? StRd : StDone;
                end
            end
            StRd: begin
                if (mem_rd_valid) begin
                    buf_d   = mem_rd_data;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (mem_wr_ack) begin
                    // Pointers wrap modulo 2^WIDTH by plain overflow.
                    src_d   = src_q + WIDTH'(1);
                    dst_d   = dst_q + WIDTH'(1);
                    count_d = count_inc;
                    state_d = (count_inc == len_q) ? StDone : StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_rd_req  = (state_q == StRd);
    assign mem_wr_req  = (state_q == StWr);
    assign mem_rd_addr = src_q;
    assign mem_wr_addr = dst_q;
    assign mem_wr_data = buf_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign xfer_count  = count_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Randomised self-checking bench for dma_xfer_engine; expectations come from a word-by-word
// model of the transfer (read src+i, write dst+i, waits chosen by the bench).
module tb_dma_xfer_engine;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         start;
    logic [W-1:0] src_addr, dst_addr, data_len;
    logic         mem_rd_req, mem_rd_valid, mem_wr_req, mem_wr_ack;
    logic [W-1:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
    logic         busy, done;
    logic [W-1:0] xfer_count;

    int n_vec = 0;
    int n_err = 0;

    dma_xfer_engine #(.WIDTH(W)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .data_len    (data_len),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .busy        (busy),
        .done        (done),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, W'(busy), 8'd0);
        check({tag, "_done"}, W'(done), 8'd0);
        check({tag, "_rdreq"}, W'(mem_rd_req), 8'd0);
        check({tag, "_wrreq"}, W'(mem_wr_req), 8'd0);
    endtask

    // Scramble the register-file side so any late capture would be visible.
    task automatic disturb_regs(input bit pulse);
        start    = pulse;
        src_addr = W'($urandom);
        dst_addr = W'($urandom);
        data_len = W'($urandom_range(9, 1));
    endtask

    // One full transfer. rw/ww < 0 selects random waits 0..3 per word.
    task automatic run_xfer(input logic [W-1:0] s, input logic [W-1:0] d, input logic [W-1:0] l,
                            input logic [W-1:0] key, input int rw, input int ww,
                            input bit busy_starts);
        logic [W-1:0] ra, wa, rdat;
        int           rd_w, wr_w, writes;
        writes = 0;
        @(negedge clk);
        check_idle_outputs("pre");
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        data_len = l;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(l); i++) begin
            ra   = s + W'(i);
            wa   = d + W'(i);
            rdat = ra + key;
            rd_w = (rw < 0) ? int'($urandom_range(3, 0)) : rw;
            wr_w = (ww < 0) ? int'($urandom_range(3, 0)) : ww;
            for (int w = 0; w <= rd_w; w++) begin
                check("rd_req", W'(mem_rd_req), 8'd1);
                check("rd_wrreq", W'(mem_wr_req), 8'd0);
                check("rd_addr", mem_rd_addr, ra);
                check("rd_busy", W'(busy), 8'd1);
                check("rd_done", W'(done), 8'd0);
                check("rd_cnt", xfer_count, W'(i));
                if (busy_starts) disturb_regs(1'b1);
                mem_rd_valid = (w == rd_w);
                mem_rd_data  = (w == rd_w) ? rdat : W'($urandom);
                mem_wr_ack   = 1'($urandom);
                @(negedge clk);
            end
            mem_rd_valid = 1'b0;
            for (int w = 0; w <= wr_w; w++) begin
                check("wr_req", W'(mem_wr_req), 8'd1);
                check("wr_rdreq", W'(mem_rd_req), 8'd0);
                check("wr_addr", mem_wr_addr, wa);
                check("wr_data", mem_wr_data, rdat);
                check("wr_cnt", xfer_count, W'(i));
                if (busy_starts) disturb_regs(1'b1);
                mem_wr_ack   = (w == wr_w);
                mem_rd_valid = 1'($urandom);
                mem_rd_data  = W'($urandom);
                if (w == wr_w) writes++;
                @(negedge clk);
            end
            mem_wr_ack   = 1'b0;
            mem_rd_valid = 1'b0;
        end
        check("dn_done", W'(done), 8'd1);
        check("dn_busy", W'(busy), 8'd1);
        check("dn_rdreq", W'(mem_rd_req), 8'd0);
        check("dn_wrreq", W'(mem_wr_req), 8'd0);
        check("dn_cnt", xfer_count, l);
        check("dn_writes", W'(writes), l);
        // A start coinciding with done must be ignored.
        disturb_regs(1'b1);
        mem_rd_valid = 1'b1;
        mem_wr_ack   = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        mem_rd_valid = 1'b0;
        mem_wr_ack   = 1'b0;
        check_idle_outputs("post");
        check("post_cnt", xfer_count, l);
    endtask

    initial begin
        arst_n       = 1'b1;
        start        = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        data_len     = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        mem_wr_ack   = 1'b0;
        #12;
        check_idle_outputs("rst");
        check("rst_cnt", xfer_count, 8'd0);
        check("rst_rdaddr", mem_rd_addr, 8'd0);
        check("rst_wrdata", mem_wr_data, 8'd0);
        @(negedge clk);
        arst_n = 1'b0;

        // Directed cases from the test plan.
        run_xfer(8'h10, 8'h40, 8'd3, 8'h80, 0, 0, 1'b0);
        run_xfer(8'h20, 8'h60, 8'd2, 8'h80, 3, 2, 1'b0);
        run_xfer(8'hFE, 8'hFF, 8'd3, 8'h80, 0, 0, 1'b0);
        run_xfer(8'h33, 8'h44, 8'd0, 8'h80, 0, 0, 1'b0);
        run_xfer(8'h50, 8'h70, 8'd4, 8'h80, -1, -1, 1'b1);

        // Reset in the middle of a write handshake.
        @(negedge clk);
        start    = 1'b1;
        src_addr = 8'hA0;
        dst_addr = 8'hB0;
        data_len = 8'd4;
        @(negedge clk);
        start        = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 8'h5C;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        check("mid_wrreq", W'(mem_wr_req), 8'd1);
        arst_n = 1'b1;
        #1;
        check_idle_outputs("arst");
        check("arst_cnt", xfer_count, 8'd0);
        check("arst_rdaddr", mem_rd_addr, 8'd0);
        check("arst_wraddr", mem_wr_addr, 8'd0);
        check("arst_wrdata", mem_wr_data, 8'd0);
        @(negedge clk);
        arst_n = 1'b0;
        run_xfer(8'hC3, 8'h07, 8'd2, 8'h11, 0, 0, 1'b0);

        // Randomised transfers.
        for (int t = 0; t < 25; t++) begin
            run_xfer(W'($urandom), W'($urandom), W'($urandom_range(6, 0)), W'($urandom),
                     -1, -1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
